// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types and defaults for the data-memory stall controller
package pipeline_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ERROR} dsc_state_t;
  localparam int MAX_WAIT_DEF = 16;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts unanswered memory wait cycles and flags the last permitted one
module wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear ? '0 : enable ? cnt + 8'd1 : cnt;
  assign expire = cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: data-memory handshake FSM driving pipeline stalls, flushes and a stall counter
module dmem_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 MemReqM,
  input  logic                 MemWriteM,
  input  logic                 LwStallD,
  input  logic                 PCSrcE,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 mem_err,
  output logic [CNT_WIDTH-1:0] stall_cycles
);
  if (MAX_WAIT < 2 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("MAX_WAIT out of range 2..255");
  end
  dsc_state_t state;
  logic expire, in_idle, in_wait, in_err, mstall, busy, to_err;
  assign in_idle = state == IDLE;
  assign in_wait = state == WAIT;
  assign in_err  = state == ERROR;
  assign mstall  = in_err | (in_wait & ~mem_ready) | (in_idle & MemReqM & ~mem_ready);
  assign busy    = ~in_err & (in_wait | MemReqM);
  assign to_err  = in_wait & ~mem_ready & expire;
  wait_timer #(.LIMIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (~in_wait),
    .enable (in_wait & ~mem_ready),
    .expire (expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= in_idle ? ((MemReqM && !mem_ready) ? WAIT : IDLE)
                    : in_wait ? (mem_ready ? IDLE : expire ? ERROR : WAIT)
                    : ERROR;
      mem_err      <= mem_err | to_err;
      stall_cycles <= (mstall && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
    end
  // every output is gated by rst_n so the pipeline sees silence while reset is held
  assign mem_req = rst_n & busy;
  assign mem_we  = rst_n & busy & MemWriteM;
  assign StallF  = rst_n & (mstall | LwStallD);
  assign StallD  = rst_n & (mstall | LwStallD);
  assign StallE  = rst_n & mstall;
  assign StallM  = rst_n & mstall;
  assign FlushD  = rst_n & ~mstall & PCSrcE;
  assign FlushE  = rst_n & ~mstall & (LwStallD | PCSrcE);
  assign FlushW  = rst_n & mstall & ~in_err;
endmodule
